// File: rtl/input_module.sv
// Elevator button front end: sync, tick-sampled debounce, and persistent request latches.
// Optional INPUT_CANCEL_EN: a repeated car-button press cancels that car request.
module input_module_lane (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic press
);
  logic       s1, s2, db, db_d;
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 2'b00;
      db   <= 1'b0;
      db_d <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      if (tick) hist <= {hist[0], s2};
      if (hist == 2'b11)      db <= 1'b1;
      else if (hist == 2'b00) db <= 1'b0;
      db_d <= db;
    end
  end

  assign press = db & ~db_d;
endmodule

module input_module #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] key_in,
  input  logic [9:0] key_out,
  input  logic [2:0] now,
  input  logic       serve,
  output logic [5:0] input_in,
  output logic [9:0] input_out,
  output logic       req_any
);
  localparam int NUM_LANES = 16;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef struct packed {
    logic [5:0] car;
    logic [9:0] hall;
  } req_t;

  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [NUM_LANES-1:0] raw, press;
  req_t                 prs, clr, nxt;

  assign tick = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + CW'(1);
  end

  assign raw = {key_out, key_in};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      input_module_lane u_lane (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (raw[i]),
        .press (press[i])
      );
    end
  endgenerate

  assign prs.car  = press[5:0];
  assign prs.hall = press[15:6];

  // Floor f clears its car bit, its UP bit (f<=5) and its DOWN bit (f>=2); now=0/7 clears nothing.
  always_comb begin
    clr = '0;
    if (serve) begin
      for (int k = 1; k <= 6; k++) begin
        if (now == 3'(k)) begin
          clr.car[k-1] = 1'b1;
          if (k <= 5) clr.hall[k-1] = 1'b1;
          if (k >= 2) clr.hall[k+3] = 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef INPUT_CANCEL_EN
    nxt.car  = (input_in ^ prs.car) & ~clr.car;
`else
    nxt.car  = (input_in | prs.car) & ~clr.car;
`endif
    nxt.hall = (input_out | prs.hall) & ~clr.hall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_in  <= '0;
      input_out <= '0;
      req_any   <= 1'b0;
    end else begin
      input_in  <= nxt.car;
      input_out <= nxt.hall;
      req_any   <= |nxt;
    end
  end
endmodule

// File: tb/tb_input_module.sv
// Directed bench for input_module with a 4-cycle debounce tick.
module tb_input_module;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] key_in = '0;
  logic [9:0] key_out = '0;
  logic [2:0] now = 3'd1;
  logic       serve = 1'b0;
  logic [5:0] input_in;
  logic [9:0] input_out;
  logic       req_any;

  int checks = 0;
  int errors = 0;

  input_module #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_out(key_out),
    .now(now), .serve(serve), .input_in(input_in), .input_out(input_out),
    .req_any(req_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] kin;
    logic [9:0] kout;
    logic [2:0] fl;
    logic       srv;
    logic [5:0] ein;
    logic [9:0] eout;
    logic       eany;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic press_car(input int b);
    key_in[b] = 1'b1;
    step(20);
    key_in[b] = 1'b0;
    step(20);
  endtask

  initial begin
    logic       seen;
    logic [9:0] tmp_out;
    logic       cancel_exp;

    vt[0] = '{6'b001000, 10'b0000000000, 3'd1, 1'b0, 6'b001000, 10'b0000000000, 1'b1};
    vt[1] = '{6'b100001, 10'b1000000101, 3'd2, 1'b0, 6'b100001, 10'b1000000101, 1'b1};
    vt[2] = '{6'b111111, 10'b1111111111, 3'd0, 1'b1, 6'b111111, 10'b1111111111, 1'b1};
    vt[3] = '{6'b111111, 10'b1111111111, 3'd3, 1'b1, 6'b111011, 10'b1110111011, 1'b1};
    vt[4] = '{6'b010000, 10'b0000000000, 3'd5, 1'b1, 6'b000000, 10'b0000000000, 1'b0};
    vt[5] = '{6'b100000, 10'b1000000000, 3'd6, 1'b1, 6'b000000, 10'b0000000000, 1'b0};
    vt[6] = '{6'b000001, 10'b0000010000, 3'd6, 1'b1, 6'b000001, 10'b0000010000, 1'b1};
    vt[7] = '{6'b000001, 10'b0000000000, 3'd7, 1'b1, 6'b000001, 10'b0000000000, 1'b1};

    step(2);
    chk("reset_in", 32'(input_in), 32'd0);
    chk("reset_out", 32'(input_out), 32'd0);
    chk("reset_any", 32'(req_any), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      now = vt[i].fl; serve = vt[i].srv;
      key_in = vt[i].kin; key_out = vt[i].kout;
      step(20);
      key_in = '0; key_out = '0;
      step(14);
      chk($sformatf("vec%0d_in", i), 32'(input_in), 32'(vt[i].ein));
      chk($sformatf("vec%0d_out", i), 32'(input_out), 32'(vt[i].eout));
      chk($sformatf("vec%0d_any", i), 32'(req_any), 32'(vt[i].eany));
    end

    // Car press latency: must land within the 2*D+4 worst case.
    now = 3'd1; serve = 1'b0;
    do_reset();
    key_in[3] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      step(1);
      if (input_in == 6'b001000) seen = 1'b1;
    end
    chk("car_latency", 32'(seen), 32'd1);
    chk("car_any", 32'(req_any), 32'd1);
    step(8);
    key_in[3] = 1'b0;
    step(20);
    chk("car_held", 32'(input_in), 32'b001000);

    // Two-cycle glitch on a hall line never registers.
    key_out[2] = 1'b1;
    step(2);
    key_out[2] = 1'b0;
    step(20);
    chk("glitch_out", 32'(input_out), 32'd0);

    // Service clear at floor 3 with floor 4 car request still pending.
    key_in[2] = 1'b1; key_out[2] = 1'b1; key_out[6] = 1'b1;
    step(20);
    key_in = '0; key_out = '0;
    step(14);
    chk("pre_clear_in", 32'(input_in), 32'b001100);
    chk("pre_clear_out", 32'(input_out), 32'b0001000100);
    now = 3'd3; serve = 1'b1;
    step(1);
    chk("clear3_in", 32'(input_in), 32'b001000);
    chk("clear3_out", 32'(input_out), 32'd0);
    chk("clear3_any", 32'(req_any), 32'd1);
    now = 3'd4;
    step(1);
    chk("clear4_in", 32'(input_in), 32'd0);
    chk("clear4_any", 32'(req_any), 32'd0);

    // Invalid floor with serve held leaves requests alone.
    now = 3'd1; serve = 1'b0;
    key_in[5] = 1'b1; key_out[8] = 1'b1;
    step(20);
    key_in = '0; key_out = '0;
    step(14);
    tmp_out = input_out;
    now = 3'd0; serve = 1'b1;
    step(6);
    chk("inval_in", 32'(input_in), 32'b100000);
    chk("inval_out", 32'(input_out), 32'(tmp_out));
    chk("inval_out_val", 32'(input_out), 32'b0100000000);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("async_in", 32'(input_in), 32'd0);
    chk("async_out", 32'(input_out), 32'd0);
    chk("async_any", 32'(req_any), 32'd0);
    step(1);
    rst = 1'b0;

    // Repeated car press: cancel build toggles the bit back off.
    now = 3'd1; serve = 1'b0;
    press_car(1);
    chk("cancel_first", 32'(input_in), 32'b000010);
`ifdef INPUT_CANCEL_EN
    cancel_exp = 1'b0;
`else
    cancel_exp = 1'b1;
`endif
    press_car(1);
    chk("cancel_second", 32'(input_in[1]), 32'(cancel_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
